// File: rtl/meta_pkg.sv
// rtl/meta_pkg.sv - shared tokens, stream length and FSM states for the metadata streamer
package meta_pkg;

  localparam logic [7:0] META_NAME       = 8'h01;
  localparam logic [7:0] META_FWVER      = 8'h02;
  localparam logic [7:0] META_SAMPLE_MEM = 8'h21;
  localparam logic [7:0] META_MAX_RATE   = 8'h23;
  localparam logic [7:0] META_PROBES     = 8'h40;
  localparam logic [7:0] META_PROTO      = 8'h41;
  localparam logic [7:0] META_END        = 8'h00;

  localparam int META_LEN = 47;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAITACK  = 2'd2,
    WAITIDLE = 2'd3
  } meta_state_t;

endpackage

// File: rtl/meta_rom.sv
// rtl/meta_rom.sv - parameter-built 64x8 metadata ROM; META_LIVE_EN replaces the sample-memory payload
module meta_rom
  import meta_pkg::*;
#(
  parameter logic [31:0] SAMPLE_BYTES = 32'h0000_6000,
  parameter logic [31:0] MAX_RATE_HZ  = 32'd200_000_000,
  parameter logic [7:0]  PROBES       = 8'd32,
  parameter logic [7:0]  PROTO_VER    = 8'd2
) (
  input  logic [5:0]  addr,
`ifdef META_LIVE_EN
  input  logic [31:0] live_bytes,
`endif
  output logic [7:0]  data
);

  localparam logic [191:0] NAME_STR = "Open Logic Sniffer v1.01";
  localparam logic [31:0]  FW_STR   = "3.08";

  logic [31:0] sample_word;
  int          idx;

`ifdef META_LIVE_EN
  assign sample_word = live_bytes;
`else
  assign sample_word = SAMPLE_BYTES;
`endif

  // Layout: name field 0..25, firmware 26..31, then the 32-bit and 8-bit fields, end flag at 46
  always_comb begin
    data = META_END;
    idx  = int'(addr);
    if (idx == 0)       data = META_NAME;
    else if (idx <= 24) data = NAME_STR[8*(24-idx) +: 8];
    else if (idx == 25) data = META_END;
    else if (idx == 26) data = META_FWVER;
    else if (idx <= 30) data = FW_STR[8*(30-idx) +: 8];
    else if (idx == 31) data = META_END;
    else if (idx == 32) data = META_SAMPLE_MEM;
    else if (idx <= 36) data = sample_word[8*(36-idx) +: 8];
    else if (idx == 37) data = META_MAX_RATE;
    else if (idx <= 41) data = MAX_RATE_HZ[8*(41-idx) +: 8];
    else if (idx == 42) data = META_PROBES;
    else if (idx == 43) data = PROBES;
    else if (idx == 44) data = META_PROTO;
    else if (idx == 45) data = PROTO_VER;
    else                data = META_END;
  end

endmodule

// File: rtl/meta_streamer.sv
// rtl/meta_streamer.sv - streams the metadata ROM into the SPI transmitter; META_LIVE_EN adds meta_live_bytes
module meta_streamer
  import meta_pkg::*;
#(
  parameter logic [31:0] SAMPLE_BYTES = 32'h0000_6000,
  parameter logic [31:0] MAX_RATE_HZ  = 32'd200_000_000,
  parameter logic [7:0]  PROBES       = 8'd32,
  parameter logic [7:0]  PROTO_VER    = 8'd2,
  parameter int          ACK_TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        query_metadata,
  input  logic        meta_abort,
  input  logic        xmit_idle,
`ifdef META_LIVE_EN
  input  logic [31:0] meta_live_bytes,
`endif
  output logic        writeMeta,
  output logic [7:0]  meta_data,
  output logic        meta_busy
);

  localparam int               TMO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [5:0]       LAST_SEL = 6'(META_LEN - 1);

  meta_state_t      state, next_state;
  logic [5:0]       metasel;
  logic [TMO_W-1:0] tmo;
  logic             query_q;
  logic             q_rise;

  assign q_rise = query_metadata & ~query_q;

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (meta_abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (q_rise && xmit_idle) next_state = SEND;
        SEND:     next_state = WAITACK;
        // A transmitter that never drops idle is treated as having taken the byte
        WAITACK:  if (!xmit_idle || tmo == TMO_LAST) next_state = WAITIDLE;
        WAITIDLE: if (xmit_idle) next_state = (metasel == LAST_SEL) ? IDLE : SEND;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    writeMeta = (state == SEND);
    meta_busy = (state != IDLE);
  end

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      metasel <= '0;
      tmo     <= '0;
      query_q <= 1'b0;
    end else begin
      query_q <= query_metadata;
      if (meta_abort) begin
        metasel <= '0;
      end else begin
        case (state)
          IDLE:     metasel <= '0;
          SEND:     tmo <= '0;
          WAITACK:  if (xmit_idle) tmo <= tmo + 1'b1;
          WAITIDLE: if (xmit_idle) metasel <= (metasel == LAST_SEL) ? 6'd0 : metasel + 6'd1;
          default:  metasel <= '0;
        endcase
      end
    end
  end

`ifdef META_LIVE_EN
  logic [31:0] live_q;

  // Captured once per stream so all four payload bytes describe the same value
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset)                              live_q <= '0;
    else if (state == IDLE && next_state == SEND) live_q <= meta_live_bytes;
  end
`endif

  meta_rom #(
    .SAMPLE_BYTES (SAMPLE_BYTES),
    .MAX_RATE_HZ  (MAX_RATE_HZ),
    .PROBES       (PROBES),
    .PROTO_VER    (PROTO_VER)
  ) u_rom (
    .addr       (metasel),
`ifdef META_LIVE_EN
    .live_bytes (live_q),
`endif
    .data       (meta_data)
  );

endmodule

// File: tb/tb_meta_streamer.sv
// tb/tb_meta_streamer.sv - directed self-checking bench for meta_streamer (META_LIVE_EN adds test_live)
module tb_meta_streamer;

  localparam int N_BYTES = 47;
  localparam int ACK_TMO = 16;

  logic        clock = 1'b0;
  logic        extReset = 1'b1;
  logic        query_metadata = 1'b0;
  logic        meta_abort = 1'b0;
  logic        xmit_idle = 1'b1;
  logic        writeMeta;
  logic [7:0]  meta_data;
  logic        meta_busy;
`ifdef META_LIVE_EN
  logic [31:0] live_bytes = 32'h0000_6000;
`endif

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [7:0]  wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  exp_rom[N_BYTES];

  meta_streamer #(
    .SAMPLE_BYTES (32'h0000_6000),
    .MAX_RATE_HZ  (32'd200_000_000),
    .PROBES       (8'd32),
    .PROTO_VER    (8'd2),
    .ACK_TIMEOUT  (ACK_TMO)
  ) dut (
    .clock           (clock),
    .extReset        (extReset),
    .query_metadata  (query_metadata),
    .meta_abort      (meta_abort),
    .xmit_idle       (xmit_idle),
`ifdef META_LIVE_EN
    .meta_live_bytes (live_bytes),
`endif
    .writeMeta       (writeMeta),
    .meta_data       (meta_data),
    .meta_busy       (meta_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #1;
    if (writeMeta === 1'b1) begin
      wr_data.push_back(meta_data);
      wr_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0] got(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 8'hxx;
  endfunction

  task automatic build_expected();
    logic [191:0] name_s;
    logic [31:0]  fw_s;
    name_s = "Open Logic Sniffer v1.01";
    fw_s   = "3.08";
    exp_rom[0] = 8'h01;
    for (int i = 0; i < 24; i++) exp_rom[1+i] = name_s[8*(23-i) +: 8];
    exp_rom[25] = 8'h00;
    exp_rom[26] = 8'h02;
    for (int i = 0; i < 4; i++) exp_rom[27+i] = fw_s[8*(3-i) +: 8];
    exp_rom[31] = 8'h00;
    exp_rom[32] = 8'h21; exp_rom[33] = 8'h00; exp_rom[34] = 8'h00; exp_rom[35] = 8'h60; exp_rom[36] = 8'h00;
    exp_rom[37] = 8'h23; exp_rom[38] = 8'h0B; exp_rom[39] = 8'hEB; exp_rom[40] = 8'hC2; exp_rom[41] = 8'h00;
    exp_rom[42] = 8'h40; exp_rom[43] = 8'h20; exp_rom[44] = 8'h41; exp_rom[45] = 8'h02; exp_rom[46] = 8'h00;
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_write(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (writeMeta === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    extReset = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (writeMeta !== 1'b0) begin fails++; $display("FAIL reset_write: got %b want 0", writeMeta); end
    tests++;
    if (meta_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", meta_busy); end
    tests++;
    if (meta_data !== 8'h01) begin fails++; $display("FAIL reset_data: got %h want 01", meta_data); end
    extReset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_full_stream();
    logic [7:0] head[5] = '{8'h01, 8'h4F, 8'h70, 8'h65, 8'h6E};
    logic [7:0] rate[5] = '{8'h23, 8'h0B, 8'hEB, 8'hC2, 8'h00};
    int bad;
    bit ok;
    clear_log();
    xmit_idle = 1'b1;
    @(negedge clock);
    query_metadata = 1'b1;
    @(negedge clock);
    tests++;
    if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      fails++; $display("FAIL latency: write=%b data=%h want 1/01", writeMeta, meta_data);
    end
    for (int i = 0; i < N_BYTES; i++) begin
      wait_write(100, ok);
      if (!ok) begin
        tests++; fails++; $display("FAIL full_timeout: stalled at byte %0d want 47 writes", i);
        break;
      end
      if (i == 0) query_metadata = 1'b0;
      repeat (2) @(negedge clock);
      xmit_idle = 1'b0;
      repeat (10) @(negedge clock);
      xmit_idle = 1'b1;
      if (i == N_BYTES - 1) begin
        tests++;
        if (meta_busy !== 1'b1) begin fails++; $display("FAIL busy_before_end: got %b want 1", meta_busy); end
      end
    end
    @(negedge clock);
    tests++;
    if (meta_busy !== 1'b0) begin fails++; $display("FAIL busy_after_end: got %b want 0", meta_busy); end
    tests++;
    if (wr_data.size() != N_BYTES) begin fails++; $display("FAIL full_count: got %0d want 47", wr_data.size()); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (got(i) !== head[i]) begin fails++; $display("FAIL head_byte%0d: got %h want %h", i, got(i), head[i]); end
      tests++;
      if (got(37+i) !== rate[i]) begin fails++; $display("FAIL rate_byte%0d: got %h want %h", 37+i, got(37+i), rate[i]); end
    end
    tests++;
    if (got(46) !== 8'h00) begin fails++; $display("FAIL end_byte: got %h want 00", got(46)); end
    bad = 0;
    for (int i = 0; i < N_BYTES; i++) if (got(i) !== exp_rom[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL full_content: %0d bytes differ want 0", bad); end
  endtask

  task automatic test_timeout_spacing();
    int bad;
    int n;
    clear_log();
    xmit_idle = 1'b1;
    @(negedge clock);
    query_metadata = 1'b1;
    @(negedge clock);
    query_metadata = 1'b0;
    n = 0;
    while (!(wr_data.size() == N_BYTES && meta_busy === 1'b0) && n < N_BYTES * (ACK_TMO + 2) + 100) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (wr_data.size() != N_BYTES || meta_busy !== 1'b0) begin
      fails++; $display("FAIL tmo_count: got %0d writes busy=%b want 47/0", wr_data.size(), meta_busy);
    end
    bad = 0;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != ACK_TMO + 2) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL tmo_spacing: %0d gaps wrong want 0", bad); end
    tests++;
    if (wr_cyc.size() < 2 || wr_cyc[1] - wr_cyc[0] != 18) begin
      fails++; $display("FAIL tmo_first_gap: got %0d want 18", (wr_cyc.size() < 2) ? -1 : wr_cyc[1] - wr_cyc[0]);
    end
    bad = 0;
    for (int i = 0; i < N_BYTES; i++) if (got(i) !== exp_rom[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL tmo_content: %0d bytes differ want 0", bad); end
  endtask

  task automatic test_query_held();
    clear_log();
    xmit_idle = 1'b1;
    @(negedge clock);
    query_metadata = 1'b1;
    repeat (N_BYTES * (ACK_TMO + 2) + 500) @(negedge clock);
    tests++;
    if (wr_data.size() != N_BYTES) begin fails++; $display("FAIL held_count: got %0d want 47", wr_data.size()); end
    tests++;
    if (meta_busy !== 1'b0) begin fails++; $display("FAIL held_busy: got %b want 0", meta_busy); end
    query_metadata = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_abort();
    bit ok;
    clear_log();
    xmit_idle = 1'b1;
    @(negedge clock);
    query_metadata = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      wait_write(50, ok);
      if (!ok) begin
        tests++; fails++; $display("FAIL abort_timeout: stalled at byte %0d", i);
        break;
      end
      if (i == 0) query_metadata = 1'b0;
      if (i < 10) @(negedge clock);
    end
    xmit_idle = 1'b0;
    repeat (2) @(negedge clock);
    meta_abort = 1'b1;
    @(negedge clock);
    meta_abort = 1'b0;
    tests++;
    if (meta_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", meta_busy); end
    tests++;
    if (meta_data !== 8'h01) begin fails++; $display("FAIL abort_data: got %h want 01", meta_data); end
    xmit_idle = 1'b1;
    repeat (40) @(negedge clock);
    tests++;
    if (wr_data.size() != 11) begin fails++; $display("FAIL abort_count: got %0d want 11", wr_data.size()); end
    tests++;
    if (got(10) !== 8'h63) begin fails++; $display("FAIL abort_byte10: got %h want 63", got(10)); end
    query_metadata = 1'b1;
    @(negedge clock);
    tests++;
    if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      fails++; $display("FAIL restart: write=%b data=%h want 1/01", writeMeta, meta_data);
    end
    meta_abort = 1'b1;
    @(negedge clock);
    meta_abort = 1'b0;
    query_metadata = 1'b0;
    tests++;
    if (meta_busy !== 1'b0) begin fails++; $display("FAIL abort_in_send: busy=%b want 0", meta_busy); end
    repeat (40) @(negedge clock);
    tests++;
    if (wr_data.size() != 12) begin fails++; $display("FAIL abort_send_count: got %0d want 12", wr_data.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    xmit_idle = 1'b1;
    @(negedge clock);
    query_metadata = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_write(50, ok);
      if (!ok) begin
        tests++; fails++; $display("FAIL rst_timeout: stalled at byte %0d", i);
        break;
      end
      if (i == 0) query_metadata = 1'b0;
      if (i < 2) @(negedge clock);
    end
    #2 extReset = 1'b1;
    #1;
    tests++;
    if (writeMeta !== 1'b0 || meta_busy !== 1'b0 || meta_data !== 8'h01) begin
      fails++; $display("FAIL async_reset: write=%b busy=%b data=%h want 0/0/01", writeMeta, meta_busy, meta_data);
    end
    @(negedge clock);
    extReset = 1'b0;
    repeat (50) @(negedge clock);
    tests++;
    if (wr_data.size() != 3) begin fails++; $display("FAIL rst_no_resume: got %0d writes want 3", wr_data.size()); end
    query_metadata = 1'b1;
    @(negedge clock);
    tests++;
    if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      fails++; $display("FAIL rst_restart: write=%b data=%h want 1/01", writeMeta, meta_data);
    end
    meta_abort = 1'b1;
    @(negedge clock);
    meta_abort = 1'b0;
    query_metadata = 1'b0;
    @(negedge clock);
  endtask

`ifdef META_LIVE_EN
  task automatic test_live();
    logic [7:0] want[4] = '{8'h00, 8'h01, 8'h00, 8'h00};
    int n;
    clear_log();
    live_bytes = 32'h0001_0000;
    xmit_idle = 1'b1;
    @(negedge clock);
    query_metadata = 1'b1;
    @(negedge clock);
    query_metadata = 1'b0;
    n = 0;
    while (wr_data.size() < 5 && n < 200) begin @(negedge clock); n++; end
    live_bytes = 32'h0000_0000;
    n = 0;
    while (!(wr_data.size() == N_BYTES && meta_busy === 1'b0) && n < 1000) begin @(negedge clock); n++; end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got(33+i) !== want[i]) begin fails++; $display("FAIL live_byte%0d: got %h want %h", 33+i, got(33+i), want[i]); end
    end
    live_bytes = 32'h0000_6000;
  endtask
`endif

  initial begin
    build_expected();
    test_reset();
    test_full_stream();
    test_timeout_spacing();
    test_query_held();
    test_abort();
    test_reset_mid();
`ifdef META_LIVE_EN
    test_live();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
